// File: rtl/des_key_scheduler.sv
// des_key_scheduler: DES round-key sequencer.
// Captures a 64-bit key on start, applies PC-1, then walks the 28-bit C/D
// halves through the 16-round rotation schedule. Each round key (PC-2) is
// presented on a valid/ready handshake, either in encrypt order (K1..K16)
// or in decrypt order (K16..K1).
// Optional build macro: KEY_PARITY_CHK_EN adds per-byte odd-parity checking
// of KEY at start time and the parity_err output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; C/D hold their last value
// GEN    | computing PC-2 of current C/D into round_key
// WAIT   | round_key valid, waiting for consumer handshake
// DONE   | one-cycle done pulse, then back to IDLE
module des_key_scheduler #(
    parameter int          NUM_ROUNDS  = 16,
    parameter logic [15:0] SHIFT_SCHED = 16'h7EFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic        abort,
    input  logic [63:0] KEY,
    output logic [47:0] round_key,
    output logic        round_key_valid,
    input  logic        round_key_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
`ifdef KEY_PARITY_CHK_EN
    output logic        parity_err,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    // Tables hold FIPS 1-based bit numbers; converted to 0-based at use.
    localparam logic [5:0] PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  sel;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            sel  = PC1_TBL[j] - 6'd1;
            r[j] = k[sel];
        end
        return r;
    endfunction

    // cd packs D above C so FIPS bit m of the C||D concatenation is cd[m-1].
    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  sel;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            sel  = PC2_TBL[j] - 6'd1;
            r[j] = cd[sel];
        end
        return r;
    endfunction

    // right=0 is the encrypt (FIPS left) rotation, right=1 the decrypt one.
    function automatic logic [27:0] rot_f(input logic [27:0] x, input logic right,
                                         input logic two);
        logic [27:0] y;
        y = right ? {x[26:0], x[27]} : {x[0], x[27:1]};
        if (two) begin
            y = right ? {y[26:0], y[27]} : {y[0], y[27:1]};
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [47:0] round_key_q, round_key_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        parity_err_q, parity_err_d;
    logic [55:0] pc1_key;
    logic        key_par_ok;
    logic        hs;
    logic        enc_shift_two;
    logic        dec_shift_two;

`ifndef KEY_PARITY_CHK_EN
    // Parity bits of KEY never reach PC-1 when the check is compiled out.
    logic unused_key_par;
    assign unused_key_par = ^{KEY[63], KEY[55], KEY[47], KEY[39],
                              KEY[31], KEY[23], KEY[15], KEY[7]};
`endif

    // Next-state, C/D stepping and output register computation.
    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        d_d          = d_q;
        round_key_d  = round_key_q;
        valid_d      = valid_q;
        idx_d        = idx_q;
        dec_d        = dec_q;
        parity_err_d = 1'b0;
        pc1_key      = pc1_f(KEY);
        hs           = valid_q && round_key_ready;
        // Encrypt: next key is idx+2 (bit idx+1). Decrypt: undoing key 16-idx (bit 15-idx).
        enc_shift_two = SHIFT_SCHED[idx_q + 4'd1];
        dec_shift_two = SHIFT_SCHED[~idx_q];
`ifdef KEY_PARITY_CHK_EN
        key_par_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            key_par_ok = key_par_ok & (^KEY[8*b +: 8]);
        end
`else
        key_par_ok = 1'b1;
`endif

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (!key_par_ok) begin
                            parity_err_d = 1'b1;
                        end else begin
                            dec_d = decrypt;
                            idx_d = 4'd0;
                            if (decrypt) begin
                                // C16/D16 equal C0/D0 after a full 28-bit turn.
                                c_d = pc1_key[27:0];
                                d_d = pc1_key[55:28];
                            end else begin
                                c_d = rot_f(pc1_key[27:0], 1'b0, SHIFT_SCHED[0]);
                                d_d = rot_f(pc1_key[55:28], 1'b0, SHIFT_SCHED[0]);
                            end
                            state_d = S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    round_key_d = pc2_f({d_q, c_q});
                    valid_d     = 1'b1;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    if (hs) begin
                        valid_d = 1'b0;
                        if (dec_q) begin
                            c_d = rot_f(c_q, 1'b1, dec_shift_two);
                            d_d = rot_f(d_q, 1'b1, dec_shift_two);
                        end else if (idx_q != LAST_IDX) begin
                            c_d = rot_f(c_q, 1'b0, enc_shift_two);
                            d_d = rot_f(d_q, 1'b0, enc_shift_two);
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_GEN;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    idx_d   = 4'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            c_q          <= '0;
            d_q          <= '0;
            round_key_q  <= '0;
            valid_q      <= 1'b0;
            idx_q        <= 4'd0;
            dec_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            d_q          <= d_d;
            round_key_q  <= round_key_d;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            dec_q        <= dec_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign round_key       = round_key_q;
    assign round_key_valid = valid_q;
    assign round_idx       = idx_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
`ifdef KEY_PARITY_CHK_EN
    assign parity_err      = parity_err_q;
`else
    logic unused_parity_err;
    assign unused_parity_err = parity_err_q;
`endif

endmodule
